// File: rtl/usb4_tx_pkg.sv
// usb4_tx_pkg: mode encodings, ordered-set constants and the
// per-lane ordered-set word builder for the multilane TX mux.
package usb4_tx_pkg;

    typedef enum logic [3:0] {
        SEL_G3_TS1 = 4'd2,
        SEL_G3_TS2 = 4'd3,
        SEL_G4_TS2 = 4'd5,
        SEL_G4_TS3 = 4'd6,
        SEL_G4_TS4 = 4'd7,
        SEL_DATA   = 4'd8,
        SEL_IDLE   = 4'd9
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OS,
        ST_DATA
    } state_e;

    localparam logic [63:0] G3_TS1 = 64'h0100_F0F0_0000_A5A5;
    localparam logic [63:0] G3_TS2 = 64'h0200_0F0F_0000_5A5A;
    localparam logic [63:0] G4_TS2 = 64'h5A5A_C3C3_0000_0000;
    localparam logic [63:0] G4_TS3 = 64'hA5A5_3C3C_0000_0000;
    localparam logic [63:0] G4_TS4 = 64'h0000_9696_0000_0000;

    localparam int LANE_HI = 55;
    localparam int LANE_LO = 48;
    localparam int SYM_HI  = 63;
    localparam int SYM_LO  = 56;

    function automatic logic is_g3(input logic [3:0] sel);
        return (sel == SEL_G3_TS1) || (sel == SEL_G3_TS2);
    endfunction

    function automatic state_e sel_state(input logic [3:0] sel);
        state_e s;
        s = ST_IDLE;
        unique case (1'b1)
            is_g3(sel),
            sel == SEL_G4_TS2,
            sel == SEL_G4_TS3,
            sel == SEL_G4_TS4: s = ST_OS;
            sel == SEL_DATA:   s = ST_DATA;
            default:           s = ST_IDLE;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] build_os(
        input logic [3:0] sel,
        input logic [7:0] lane,
        input logic [3:0] sym
    );
        logic [63:0] w;
        w = '0;
        unique case (1'b1)
            sel == SEL_G3_TS1: begin
                w = G3_TS1;
                w[LANE_HI:LANE_LO] = lane;
            end
            sel == SEL_G3_TS2: begin
                w = G3_TS2;
                w[LANE_HI:LANE_LO] = lane;
            end
            sel == SEL_G4_TS2: w = G4_TS2;
            sel == SEL_G4_TS3: w = G4_TS3;
            sel == SEL_G4_TS4: begin
                w = G4_TS4;
                w[SYM_HI:SYM_LO] = {sym, ~sym};
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/os_beat_slicer.sv
// os_beat_slicer: picks the MSB-first LANE_W slice of a
// lane's ordered-set word for the current beat.
module os_beat_slicer #(
    parameter int OS_BITS = 64,
    parameter int LANE_W  = 8,
    parameter int BW      = 4
) (
    input  logic [OS_BITS-1:0] word_i,
    input  logic [BW-1:0]      beat_i,
    output logic [LANE_W-1:0]  slice_o
);
    logic [31:0]        sh_amt;
    logic [OS_BITS-1:0] sh_word;

    assign sh_amt  = 32'(beat_i) * 32'(LANE_W);
    assign sh_word = word_i << sh_amt;
    assign slice_o = sh_word[OS_BITS-1 -: LANE_W];
endmodule

// File: rtl/usb4_multilane_os_tx.sv
// usb4_multilane_os_tx: per-lane ordered-set / striped data /
// idle TX mux with repeat count and data backpressure.
module usb4_multilane_os_tx
    import usb4_tx_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 8,
    parameter int OS_BITS   = 64,
    parameter int REP_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  d_sel,
    input  logic [REP_W-1:0]            os_repeat,
    input  logic [NUM_LANES*LANE_W-1:0] tl_data,
    input  logic                        tl_valid,
    output logic                        tl_ready,
    output logic [NUM_LANES*LANE_W-1:0] lane_tx,
    output logic                        tx_lanes_on,
    output logic                        os_sent,
    output logic                        os_done,
    output logic [3:0]                  sym_cnt
);
    localparam int DW = NUM_LANES * LANE_W;
    localparam int NB = OS_BITS / LANE_W;
    localparam int BW = $clog2(NB) + 1;
    localparam logic [BW-1:0] G3_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] G4_LAST = BW'(NB / 2 - 1);

    state_e           state_q, state_d;
    logic [3:0]       mode_q;
    logic [BW-1:0]    beat_q, beat_d, beat_eff;
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
    logic [3:0]       sym_q, sym_d, sym_eff;
    logic             done_q, done_d;
    logic             on_q, on_d;
    logic             sent_q, sent_d;
    logic             rdy_q, rdy_d;
    logic [DW-1:0]    lane_q, lane_d;
    logic [DW-1:0]    os_slice;
    logic             chg, last;

    // a new mode restarts the set from beat 0 with sym 0
    assign chg      = (d_sel != mode_q);
    assign beat_eff = chg ? '0 : beat_q;
    assign sym_eff  = chg ? '0 : sym_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [OS_BITS-1:0] os_word;
        assign os_word = OS_BITS'(build_os(d_sel, 8'(i), sym_eff));
        os_beat_slicer #(
            .OS_BITS (OS_BITS),
            .LANE_W  (LANE_W),
            .BW      (BW)
        ) u_slice (
            .word_i  (os_word),
            .beat_i  (beat_eff),
            .slice_o (os_slice[i*LANE_W +: LANE_W])
        );
    end

    assign tl_ready    = rdy_q & (d_sel == SEL_DATA);
    assign lane_tx     = lane_q;
    assign tx_lanes_on = on_q;
    assign os_sent     = sent_q;
    assign os_done     = done_q;
    assign sym_cnt     = sym_q;

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            beat_q  <= '0;
            rep_q   <= '0;
            sym_q   <= '0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
            sent_q  <= 1'b0;
            rdy_q   <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= d_sel;
            beat_q  <= beat_d;
            rep_q   <= rep_d;
            sym_q   <= sym_d;
            done_q  <= done_d;
            on_q    <= on_d;
            sent_q  <= sent_d;
            rdy_q   <= rdy_d;
            lane_q  <= lane_d;
        end
    end

    // next state, beat sequencing and output selection
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rep_d   = rep_q;
        sym_d   = sym_q;
        done_d  = done_q;
        on_d    = on_q;
        sent_d  = 1'b0;
        rdy_d   = 1'b0;
        lane_d  = '0;
        if (chg) begin
            state_d = sel_state(d_sel);
            beat_d  = '0;
            rep_d   = '0;
            sym_d   = '0;
            done_d  = 1'b0;
        end
        last    = (beat_d == (is_g3(d_sel) ? G3_LAST : G4_LAST));
        rep_inc = (&rep_d) ? rep_d : rep_d + 1'b1;
        unique case (state_d)
            ST_OS: begin
                if (!done_d && beat_d == '0 && os_repeat != '0
                    && rep_d >= os_repeat)
                    done_d = 1'b1;
                if (!done_d) begin
                    lane_d = os_slice;
                    on_d   = 1'b1;
                    if (last) begin
                        sent_d = 1'b1;
                        beat_d = '0;
                        rep_d  = rep_inc;
                        if (d_sel == SEL_G4_TS4 && !(&sym_d))
                            sym_d = sym_d + 1'b1;
                        if (os_repeat != '0 && rep_inc >= os_repeat)
                            done_d = 1'b1;
                    end else begin
                        beat_d = beat_d + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                rdy_d = 1'b1;
                if (tl_valid && tl_ready)
                    lane_d = tl_data;
            end
            default: begin
                lane_d = '0;
            end
        endcase
    end
endmodule

// File: doc/usb4_multilane_os_tx.md
Name: usb4_multilane_os_tx

Overview:
- Parametrised successor to the two-lane ordered-set/data transmit mux in the USB4 logical-layer TX path.
- Drives NUM_LANES lanes of LANE_W bits each, every cycle.
- Selects one of: Gen3 TS1/TS2 or Gen4 TS2/TS3/TS4 ordered sets (byte-serialised, with per-lane lane-number insertion), transport-layer data striped across lanes with a valid/ready handshake, or idle zeros.
- Adds what the previous block lacked: lane-count/width generality, programmable repeat count with done flag, and a data backpressure handshake.

Parameters:
- NUM_LANES, 2, number of TX lanes (1..4).
- LANE_W, 8, bits per lane per cycle; must divide 64.
- OS_BITS, 64, full ordered-set length; Gen4 TS2/3/4 use the upper OS_BITS/2.
- REP_W, 8, width of the repeat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- d_sel  in  4  mode: 2=G3 TS1, 3=G3 TS2, 5=G4 TS2, 6=G4 TS3, 7=G4 TS4, 8=data, 9=idle; others treated as idle.
- os_repeat  in  REP_W  number of ordered sets to send; 0 means send continuously.
- tl_data  in  NUM_LANES*LANE_W  transport data; lane i takes slice [i*LANE_W +: LANE_W].
- tl_valid  in  1  tl_data valid.
- tl_ready  out  1  block accepts tl_data this cycle.
- lane_tx  out  NUM_LANES*LANE_W  per-lane output symbols.
- tx_lanes_on  out  1  lanes enabled.
- os_sent  out  1  one-cycle pulse on the last beat of each ordered set.
- os_done  out  1  sticky; set when os_repeat sets have been sent.
- sym_cnt  out  4  current TS4 sequence number.

Behaviour:
- Reset: every output is 0. FSM is IDLE; beat, repeat and sym counters are 0.
- Registered outputs, one-cycle latency: lane_tx reflects the d_sel and beat of the previous cycle.
- FSM states: IDLE, OS, DATA.
  - Any change of d_sel moves the FSM to the state for the new mode on the next edge.
  - The change clears the beat, repeat and sym counters, clears os_done and aborts any partial ordered set (no os_sent is emitted for it).
  - d_sel = 2/3/5/6/7 → OS; d_sel = 8 → DATA; all other codes → IDLE.
- OS state:
  - Beats per set: NB = OS_BITS/LANE_W for Gen3 and NB/2 for Gen4.
  - Each beat, lane i outputs its set word slice [OS_BITS-1-beat*LANE_W -: LANE_W], MSB first.
  - Gen3 lane word: bits [55:48] are replaced by lane index i, so lane 0 carries 0x00 and lane 1 carries 0x01.
  - Gen4 TS4 word: bits [63:60] of the 32-bit header field carry sym_cnt and bits [59:56] carry ~sym_cnt.
  - On beat NB-1: os_sent=1, beat returns to 0, and rep_cnt is incremented (saturating).
  - In TS4 mode, sym_cnt increments after each set and saturates at 0xF.
  - When os_repeat≠0 and rep_cnt reaches os_repeat: os_done=1 and the FSM holds lane_tx=0 until d_sel changes.
  - tx_lanes_on=1 from the first OS beat onward.
- DATA state:
  - tl_ready=1 is registered and asserts the cycle after DATA is entered.
  - A transfer occurs when tl_valid & tl_ready; the slices are then output on lane_tx the next cycle.
  - tl_valid=0 outputs 0 on all lanes; no data is held over.
  - tl_ready drops the same cycle d_sel leaves 8; data presented on that cycle is not accepted.
- IDLE state: lane_tx=0, tl_ready=0. tx_lanes_on keeps its value and clears only on reset.
- Simultaneous events:
  - A d_sel change on the last OS beat: the mode change wins and no os_sent is emitted.
  - os_repeat changed mid-run takes effect at the next comparison.
- An asynchronous rst at any time returns everything to the reset state within the same cycle.

Decomposition:
- Package usb4_tx_pkg holds:
  - The d_sel encodings as a localparam enum.
  - The Gen3 TS1/TS2 and Gen4 TS2/TS3/TS4 64-bit constants.
  - The lane-index field position [55:48] and the sym field position [63:56].
  - A function build_os(d_sel, lane, sym), which returns the lane word.
- One sub-module, os_beat_slicer: takes a lane word and the beat index, and returns the LANE_W slice. It is instantiated per lane via generate.

Test Plan:
- Reset with rst=1 mid-OS (NUM_LANES=2) → all outputs 0 immediately; after release and d_sel=2, lane_tx first beat is lane0 0x01 and lane1 0x01, and the second beat is lane0 0x00 and lane1 0x01.
- d_sel=5, os_repeat=3 → os_sent pulses every 4 cycles, exactly 3 times; os_done=1 after the third pulse; lane_tx=0 afterwards.
- d_sel=7, os_repeat=0, run 20 sets → first header byte per set is 0x0F, 0x1E, …, 0xF0, then it stays at 0xF0.
- d_sel=8 with tl_data=0xBBAA, tl_valid toggling 1,0,1 → lane0/lane1 show AA/BB, 00/00, AA/BB; tl_ready=1 throughout after the entry cycle.
- d_sel changes from 2 to 3 at beat 7 → no os_sent pulse; the next cycle starts the TS2 beat 0.
- NUM_LANES=4, LANE_W=16 build with d_sel=3 → 4 beats per set; lane i carries lane index i in bits [55:48].
